// File: rtl/sr_mon_pkg.sv
// Shared types and constants for the SR flip-flop monitor.
// States are kept as plain localparam encodings so older code can compare
// against them; the enum reuses the same values for readable waveforms.
package sr_mon_pkg;

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_INDET   = 2'd2;

    typedef enum logic [1:0] {
        UNKNOWN = ST_UNKNOWN,
        TRACK   = ST_TRACK,
        INDET   = ST_INDET
    } state_t;

    // Command codes formed as {S, R}
    localparam logic [1:0] CMD_HOLD    = 2'b00;
    localparam logic [1:0] CMD_RST     = 2'b01;
    localparam logic [1:0] CMD_SET     = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter. Reset beats clear; clear beats increment.
// At the maximum value the counter holds instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count up on inc, stick at the maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sr_ff_monitor.sv
// Observer for an enable-gated SR flip-flop. Tracks the expected state of the
// flop from its S/R/enable pins and compares the DUT's Q/Qn against it.
// Compares at edge k use the model as it stood before that edge's update,
// i.e. the expectation formed at edge k-1.
// Optional build macro: SRM_STRICT_ILLEGAL_EN -- when defined, an accepted
// S=R=1 request is also counted as a mismatch.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  UNKNOWN | no set/reset seen since reset; only Qn == ~Q is checked
//  TRACK   | exp_q is valid; Q and Qn are both checked
//  INDET   | last accepted command was S=R=1; DUT state undefined, no checks
module sr_ff_monitor
    import sr_mon_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             S,
    input  logic             R,
    input  logic             enable,
    input  logic             Q,
    input  logic             Qn,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic [CNT_W-1:0] check_count
);

    state_t     state;
    logic [1:0] cmd;
    logic       q_check;
    logic       q_mis;
    logic       c_mis;
    logic       illegal_acc;
    logic       strict_err;
    logic       mismatch;

    assign cmd         = {S, R};
    assign illegal_acc = enable && (cmd == CMD_ILLEGAL);
    assign q_check     = (state == TRACK);
    assign q_mis       = q_check && (Q != exp_q);
    assign c_mis       = (state != INDET) && (Qn == Q);

`ifdef SRM_STRICT_ILLEGAL_EN
    assign strict_err = illegal_acc;
`else
    assign strict_err = 1'b0;
`endif

    // A Q and a Qn fault on the same edge collapse into a single error
    assign mismatch  = q_mis || c_mis || strict_err;
    assign exp_valid = (state == TRACK);

    // Reference model of the flop; only moves when the DUT is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNKNOWN;
            exp_q <= 1'b0;
        end else if (enable) begin
            case (cmd)
                CMD_SET: begin
                    state <= TRACK;
                    exp_q <= 1'b1;
                end
                CMD_RST: begin
                    state <= TRACK;
                    exp_q <= 1'b0;
                end
                CMD_ILLEGAL: begin
                    state <= INDET;
                end
                default: begin
                end
            endcase
        end
    end

    // Error flags; clr drops the sticky flag but the pulse still reports this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= mismatch;
            if (clr) begin
                err_sticky <= 1'b0;
            end else if (mismatch) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (mismatch),
        .count (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_illegal_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (illegal_acc),
        .count (illegal_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (q_check),
        .count (check_count)
    );

endmodule
